// File: rtl/stopwatch_pkg.sv
// ============================================================================
// stopwatch_pkg : shared constants, converter state encoding, 7-seg encoder
// Revision 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

   localparam logic [12:0] MAX_SECONDS = 13'd6039;
   localparam logic [12:0] SEC_PER_MIN = 13'd60;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DIV60  = 3'd1,
      DIV10M = 3'd2,
      DIV10S = 3'd3,
      COMMIT = 3'd4
   } conv_state_t;

   // Active-low {g,f,e,d,c,b,a}; non-decimal codes stay dark.
   function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h40;
         4'd1:    seg = 7'h79;
         4'd2:    seg = 7'h24;
         4'd3:    seg = 7'h30;
         4'd4:    seg = 7'h19;
         4'd5:    seg = 7'h12;
         4'd6:    seg = 7'h02;
         4'd7:    seg = 7'h78;
         4'd8:    seg = 7'h00;
         4'd9:    seg = 7'h10;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mmss_converter.sv
// ============================================================================
// mmss_converter : sequential seconds -> {m10,m1,s10,s1} BCD converter
// Revision 1.0
// ============================================================================
`default_nettype none

module mmss_converter #(
   parameter logic [12:0] MAX_SECONDS = stopwatch_pkg::MAX_SECONDS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] seconds,
   output logic [15:0] bcd,
   output logic [15:0] bcd_next,
   output logic        busy
);
   import stopwatch_pkg::*;

   conv_state_t state_q, state_d;
   logic [12:0] cap_q, cap_d, rem_q, rem_d, last_q, last_d;
   logic [6:0]  min_q, min_d;
   logic [3:0]  m10_q, m10_d, m1_q, m1_d, s10_q, s10_d, s1_q, s1_d;
   logic [15:0] bcd_q, bcd_d;
   logic        pending_q, pending_d, busy_q, busy_d;
   logic [12:0] sat;

   assign sat = (seconds > MAX_SECONDS) ? MAX_SECONDS : seconds;

   always_comb begin
      state_d   = state_q;
      cap_d     = cap_q;
      rem_d     = rem_q;
      last_d    = last_q;
      min_d     = min_q;
      m10_d     = m10_q;
      m1_d      = m1_q;
      s10_d     = s10_q;
      s1_d      = s1_q;
      bcd_d     = bcd_q;
      pending_d = pending_q;
      busy_d    = busy_q;
      case (state_q)
         IDLE: begin
            if (pending_q || (sat != last_q)) begin
               cap_d   = sat;
               rem_d   = sat;
               min_d   = 7'd0;
               busy_d  = 1'b1;
               state_d = DIV60;
            end
         end
         DIV60: begin
            if (rem_q >= SEC_PER_MIN) begin
               rem_d = rem_q - SEC_PER_MIN;
               min_d = min_q + 7'd1;
            end else begin
               // Anything past 99 minutes is pinned to 99:59 for display.
               if (min_q > 7'd99) begin
                  min_d = 7'd99;
                  rem_d = 13'd59;
               end
               m10_d   = 4'd0;
               state_d = DIV10M;
            end
         end
         DIV10M: begin
            if (min_q >= 7'd10) begin
               min_d = min_q - 7'd10;
               m10_d = m10_q + 4'd1;
            end else begin
               m1_d    = min_q[3:0];
               s10_d   = 4'd0;
               state_d = DIV10S;
            end
         end
         DIV10S: begin
            if (rem_q >= 13'd10) begin
               rem_d = rem_q - 13'd10;
               s10_d = s10_q + 4'd1;
            end else begin
               s1_d    = rem_q[3:0];
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            bcd_d     = {m10_q, m1_q, s10_q, s1_q};
            last_d    = cap_q;
            pending_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cap_q     <= '0;
         rem_q     <= '0;
         last_q    <= '0;
         min_q     <= '0;
         m10_q     <= '0;
         m1_q      <= '0;
         s10_q     <= '0;
         s1_q      <= '0;
         bcd_q     <= '0;
         pending_q <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cap_q     <= cap_d;
         rem_q     <= rem_d;
         last_q    <= last_d;
         min_q     <= min_d;
         m10_q     <= m10_d;
         m1_q      <= m1_d;
         s10_q     <= s10_d;
         s1_q      <= s1_d;
         bcd_q     <= bcd_d;
         pending_q <= pending_d;
         busy_q    <= busy_d;
      end
   end

   assign bcd      = bcd_q;
   assign bcd_next = bcd_d;
   assign busy     = busy_q;

endmodule

`default_nettype wire

// File: rtl/mmss_display_driver.sv
// ============================================================================
// mmss_display_driver : MM:SS 4-digit multiplexed 7-segment driver
// Revision 1.0
// ============================================================================
`default_nettype none

module mmss_display_driver #(
   parameter logic [12:0] MAX_SECONDS   = stopwatch_pkg::MAX_SECONDS,
   parameter bit          BLANK_LEADING = 1'b0,
   parameter int          COLON_DIGIT   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] seconds,
   input  logic        scan_tick,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic [15:0] bcd,
   output logic        busy
);
   import stopwatch_pkg::*;

   localparam logic [1:0] COLON_IDX = COLON_DIGIT[1:0];

   logic [15:0] bcd_next;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  an_q, an_d, digit;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;

   mmss_converter #(
      .MAX_SECONDS (MAX_SECONDS)
   ) u_conv (
      .clk      (clk),
      .rst      (rst),
      .seconds  (seconds),
      .bcd      (bcd),
      .bcd_next (bcd_next),
      .busy     (busy)
   );

   // Scan from the next-state bcd so a tick coinciding with COMMIT shows the new value.
   always_comb begin
      case (idx_q)
         2'd0:    digit = bcd_next[3:0];
         2'd1:    digit = bcd_next[7:4];
         2'd2:    digit = bcd_next[11:8];
         default: digit = bcd_next[15:12];
      endcase
   end

   always_comb begin
      idx_d = idx_q;
      an_d  = an_q;
      seg_d = seg_q;
      dp_d  = dp_q;
      if (scan_tick) begin
         idx_d = idx_q + 2'd1;
         an_d  = ~(4'b0001 << idx_q);
         dp_d  = (idx_q == COLON_IDX) ? 1'b0 : 1'b1;
         if (BLANK_LEADING && (idx_q == 2'd3) && (digit == 4'd0))
            seg_d = 7'h7F;
         else
            seg_d = seg7_encode(digit);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q <= 2'd0;
         an_q  <= 4'hF;
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
      end else begin
         idx_q <= idx_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

`default_nettype wire
